// File: rtl/uart_xtor_pkg.sv
// Shared types and elaboration helpers for the UART stream transactor.
package uart_xtor_pkg;

  // Frame phases, used by both the TX and the RX state machines
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Cycles from the detected start edge to the centre of the start bit
  function automatic int half_bit_count(input int clk_div);
    return clk_div / 2;
  endfunction

  // Width of an occupancy counter that must represent 0..depth inclusive
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_xtor_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers and an occupancy level.
module uart_xtor_fifo
  import uart_xtor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Equal pointers mean empty; equal index with differing wrap bit means full
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push  = push_valid & ~full;
  assign do_pop   = pop_ready & ~empty;
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];
  assign level    = LW'(wr_ptr_reg - rd_ptr_reg);

  // Storage write; no reset so the array can map onto RAM resources
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer advance on accepted push and pop
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_stream_xtor.sv
// UART transactor: host valid/ready byte streams on one side, serial pins on the other.
module uart_stream_xtor
  import uart_xtor_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LW = level_width(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 ser_rx,
  output logic                 ser_tx,
  input  logic                 h_tx_valid,
  output logic                 h_tx_ready,
  input  logic [DATA_BITS-1:0] h_tx_data,
  output logic                 h_rx_valid,
  input  logic                 h_rx_ready,
  output logic [DATA_BITS-1:0] h_rx_data,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int HALF     = half_bit_count(CLK_DIV);
  localparam int STOP_CYC = STOP_BITS * CLK_DIV;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_BITS - 1);

  // ---------------- FIFOs ----------------
  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty;
  logic                 rx_push_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;

  uart_xtor_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push_valid (h_tx_valid),
    .push_data  (h_tx_data),
    .pop_ready  (tx_pop),
    .pop_data   (tx_head),
    .level      (tx_level),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  uart_xtor_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push_valid (rx_push_reg),
    .push_data  (rx_shift_reg),
    .pop_ready  (h_rx_ready),
    .pop_data   (h_rx_data),
    .level      (rx_level),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  assign h_tx_ready = ~tx_full;
  assign h_rx_valid = ~rx_empty;

  // ---------------- TX ----------------
  uart_state_t          tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [BW-1:0]        tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 ser_tx_reg;

  // A new byte is taken when idle, or at the last stop cycle for gapless frames
  assign tx_pop = ~tx_empty &&
                  ((tx_state_reg == ST_IDLE) ||
                   ((tx_state_reg == ST_STOP) && (tx_cnt_reg == STOP_LAST)));
  assign ser_tx = ser_tx_reg;

  // TX sequencer; the line register follows the state one cycle later
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state_reg <= ST_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      ser_tx_reg   <= 1'b1;
    end else begin
      case (tx_state_reg)
        ST_IDLE: begin
          ser_tx_reg <= 1'b1;
          if (tx_pop) begin
            tx_shift_reg <= tx_head;
            tx_par_reg   <= ^tx_head;
            tx_cnt_reg   <= '0;
            tx_state_reg <= ST_START;
          end
        end
        ST_START: begin
          ser_tx_reg <= 1'b0;
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= ST_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          ser_tx_reg <= tx_shift_reg[0];
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_bit_reg   <= tx_bit_reg + 1'b1;
            if (tx_bit_reg == DBIT_LAST) begin
              if (PARITY_EN != 0) tx_state_reg <= ST_PARITY;
              else                tx_state_reg <= ST_STOP;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        ST_PARITY: begin
          ser_tx_reg <= tx_par_reg;
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= ST_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          ser_tx_reg <= 1'b1;
          if (tx_cnt_reg == STOP_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_pop) begin
              tx_shift_reg <= tx_head;
              tx_par_reg   <= ^tx_head;
              tx_state_reg <= ST_START;
            end else begin
              tx_state_reg <= ST_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: begin
          ser_tx_reg   <= 1'b1;
          tx_state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0]    rx_sync_reg;
  logic          rx_prev_reg;
  logic          rx_s;
  logic          rx_fall;
  uart_state_t   rx_state_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [BW-1:0] rx_bit_reg;
  logic          rx_par_bad_reg;
  logic          rx_frame_err_reg;
  logic          rx_parity_err_reg;
  logic          rx_overrun_reg;

  assign rx_s          = rx_sync_reg[1];
  assign rx_fall       = rx_prev_reg & ~rx_s;
  assign rx_frame_err  = rx_frame_err_reg;
  assign rx_parity_err = rx_parity_err_reg;
  assign rx_overrun    = rx_overrun_reg;

  // Two-flop synchroniser plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_sync_reg <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], ser_rx};
      rx_prev_reg <= rx_s;
    end
  end

  // RX sequencer; after a low stop bit the edge detector only rearms once the line goes high
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state_reg      <= ST_IDLE;
      rx_cnt_reg        <= '0;
      rx_bit_reg        <= '0;
      rx_shift_reg      <= '0;
      rx_par_bad_reg    <= 1'b0;
      rx_push_reg       <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_overrun_reg    <= 1'b0;
    end else begin
      rx_push_reg       <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_overrun_reg    <= rx_push_reg & rx_full;
      case (rx_state_reg)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_par_bad_reg <= 1'b0;
            if (rx_s) rx_state_reg <= ST_IDLE;
            else      rx_state_reg <= ST_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == DBIT_LAST) begin
              if (PARITY_EN != 0) rx_state_reg <= ST_PARITY;
              else                rx_state_reg <= ST_STOP;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        ST_PARITY: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg     <= '0;
            rx_par_bad_reg <= rx_s ^ (^rx_shift_reg);
            rx_state_reg   <= ST_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= ST_IDLE;
            if (rx_par_bad_reg)  rx_parity_err_reg <= 1'b1;
            else if (!rx_s)      rx_frame_err_reg  <= 1'b1;
            else                 rx_push_reg       <= 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
